tree_infer_engine: RTL and testbench

TREE_INFER_ENGINE -- requirements
Module: tree_infer_engine

---
 rtl/tree_pkg.sv | 34 +++
 rtl/tree_node_ram.sv | 25 ++
 rtl/tree_infer_engine.sv | 139 +++++++++++++
 tb/tb_tree_infer_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared node layout, leaf type code and traversal FSM states for the
// decision-tree inference engine.
package tree_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

    localparam logic [7:0] LEAF_TYPE = 8'd1;
    localparam int SPARE_W  = 2;
    localparam int TYPE_W   = 8;
    localparam int TYPE_LSB = 2;
    localparam int LEFT_LSB = TYPE_LSB + TYPE_W;

    // Node word, MSB-first: node_id, feature_id, threshold, right, left, type, spare.
    function automatic int right_lsb(int id_w);
        return LEFT_LSB + id_w;
    endfunction

    function automatic int thr_lsb(int id_w);
        return LEFT_LSB + 2 * id_w;
    endfunction

    function automatic int feat_lsb(int id_w, int thr_w);
        return thr_lsb(id_w) + thr_w;
    endfunction

    function automatic int nid_lsb(int id_w, int feat_w, int thr_w);
        return feat_lsb(id_w, thr_w) + feat_w;
    endfunction

    function automatic int node_width(int id_w, int feat_w, int thr_w);
        return 3 * id_w + feat_w + thr_w + TYPE_W + SPARE_W;
    endfunction

endpackage

// File: rtl/tree_node_ram.sv
// Node storage: one write port, one registered read port, never cleared.
module tree_node_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/tree_infer_engine.sv
// Walks a decision tree stored in node RAM for one feature vector at a time,
// two cycles per level (fetch, evaluate), and reports the leaf class.
module tree_infer_engine
    import tree_pkg::*;
#(
    parameter int N_NODES   = 256,
    parameter int ID_W      = 8,
    parameter int FEAT_W    = 3,
    parameter int THR_W     = 27,
    parameter int CLASS_W   = 8,
    parameter int MAX_STEPS = 32,
    localparam int NODE_W   = node_width(ID_W, FEAT_W, THR_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [ID_W-1:0]               cfg_addr,
    input  logic [NODE_W-1:0]             cfg_wdata,
    output logic                          cfg_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [(2**FEAT_W)*THR_W-1:0]  in_features,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CLASS_W-1:0]            out_class,
    output logic [ID_W-1:0]               out_depth,
    output logic                          out_err
);

    localparam int N_FEAT = 2**FEAT_W;
    localparam int R_LSB  = right_lsb(ID_W);
    localparam int T_LSB  = thr_lsb(ID_W);
    localparam int F_LSB  = feat_lsb(ID_W, THR_W);
    localparam int I_LSB  = nid_lsb(ID_W, FEAT_W, THR_W);
    localparam logic [ID_W:0]   NODES_L = (ID_W+1)'(N_NODES);
    localparam logic [ID_W-1:0] LAST_D  = ID_W'(MAX_STEPS - 1);

    state_t                         state;
    logic [ID_W-1:0]                node_addr;
    logic [ID_W-1:0]                depth;
    logic [N_FEAT-1:0][THR_W-1:0]   feats;
    logic [NODE_W-1:0]              rd_data;

    logic [TYPE_W-1:0] n_type;
    logic [ID_W-1:0]   n_left, n_right, nxt_id;
    logic [THR_W-1:0]  n_thr, feat_val;
    logic [FEAT_W-1:0] n_fid;
    logic              is_leaf, nxt_oob, addr_ok, wr_ok;
    logic              node_unused;

    assign n_type   = rd_data[TYPE_LSB +: TYPE_W];
    assign n_left   = rd_data[LEFT_LSB +: ID_W];
    assign n_right  = rd_data[R_LSB +: ID_W];
    assign n_thr    = rd_data[T_LSB +: THR_W];
    assign n_fid    = rd_data[F_LSB +: FEAT_W];
    // node_id and spare bits are carried for software only.
    assign node_unused = ^{rd_data[I_LSB +: ID_W], rd_data[SPARE_W-1:0]};

    assign is_leaf  = (n_type == LEAF_TYPE) || (n_left == '0 && n_right == '0);
    assign feat_val = feats[n_fid];
    assign nxt_id   = (feat_val <= n_thr) ? n_left : n_right;
    assign nxt_oob  = {1'b0, nxt_id} >= NODES_L;

    assign addr_ok  = {1'b0, cfg_addr} < NODES_L;
    assign wr_ok    = cfg_we && addr_ok && (state == IDLE) && !rst;

    tree_node_ram #(
        .DEPTH  (N_NODES),
        .ADDR_W (ID_W),
        .DATA_W (NODE_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .re    (state == FETCH),
        .raddr (node_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_depth <= '0;
            out_err   <= 1'b0;
            cfg_err   <= 1'b0;
            node_addr <= '0;
            depth     <= '0;
        end else begin
            cfg_err <= cfg_we && !(addr_ok && state == IDLE);
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        feats     <= in_features;
                        node_addr <= '0;
                        depth     <= '0;
                        in_ready  <= 1'b0;
                        state     <= FETCH;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                FETCH: state <= EVAL;
                EVAL: begin
                    if (is_leaf) begin
                        out_valid <= 1'b1;
                        out_class <= n_thr[CLASS_W-1:0];
                        out_depth <= depth;
                        out_err   <= 1'b0;
                        state     <= DONE;
                    end else if (nxt_oob || depth == LAST_D) begin
                        // Runaway or corrupt tree: stop rather than loop forever.
                        out_valid <= 1'b1;
                        out_class <= '0;
                        out_depth <= depth;
                        out_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        node_addr <= nxt_id;
                        depth     <= depth + 1'b1;
                        state     <= FETCH;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_infer_engine.sv
// Randomized and directed checks of tree_infer_engine against a plain
// tree-walk reference model.
module tb_tree_infer_engine;

    localparam int N_NODES = 256, ID_W = 8, FEAT_W = 3, THR_W = 27;
    localparam int CLASS_W = 8, MAX_STEPS = 32, N_FEAT = 8, NODE_W = 64;
    localparam int FV_W = N_FEAT * THR_W;

    logic              clk = 1'b0, rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [ID_W-1:0]   cfg_addr = '0;
    logic [NODE_W-1:0] cfg_wdata = '0;
    logic              cfg_err;
    logic              in_valid = 1'b0, in_ready;
    logic [FV_W-1:0]   in_features = '0;
    logic              out_valid, out_ready = 1'b0, out_err;
    logic [CLASS_W-1:0] out_class;
    logic [ID_W-1:0]   out_depth;

    always #5 clk = ~clk;

    tree_infer_engine #(
        .N_NODES(N_NODES), .ID_W(ID_W), .FEAT_W(FEAT_W), .THR_W(THR_W),
        .CLASS_W(CLASS_W), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_features(in_features),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_depth(out_depth), .out_err(out_err)
    );

    logic [FEAT_W-1:0] m_fid [N_NODES];
    logic [THR_W-1:0]  m_thr [N_NODES];
    logic [ID_W-1:0]   m_l   [N_NODES];
    logic [ID_W-1:0]   m_r   [N_NODES];
    logic [7:0]        m_ty  [N_NODES];

    int nchk = 0, nerr = 0;
    int e_cls, e_dep, e_err;
    logic [FV_W-1:0] fv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NODE_W-1:0] pack(input logic [ID_W-1:0] a, input logic [FEAT_W-1:0] fid,
            input logic [THR_W-1:0] thr, input logic [ID_W-1:0] r, input logic [ID_W-1:0] l,
            input logic [7:0] ty);
        return {a, fid, thr, r, l, ty, 2'b00};
    endfunction

    function automatic void mset(input logic [ID_W-1:0] a, input logic [FEAT_W-1:0] fid,
            input logic [THR_W-1:0] thr, input logic [ID_W-1:0] r, input logic [ID_W-1:0] l,
            input logic [7:0] ty);
        m_fid[a] = fid; m_thr[a] = thr; m_r[a] = r; m_l[a] = l; m_ty[a] = ty;
    endfunction

    // Reference: walk the tree from the root following the comparison rule.
    function automatic void model(input logic [FV_W-1:0] f, output int cls, output int dep, output int err);
        int id = 0;
        int d = 0;
        logic [THR_W-1:0] v;
        int nx;
        cls = 0; dep = 0; err = 1;
        for (int s = 0; s < 1000; s++) begin
            if (m_ty[id] == 8'd1 || (m_l[id] == 0 && m_r[id] == 0)) begin
                cls = int'(m_thr[id][CLASS_W-1:0]); dep = d; err = 0;
                return;
            end
            v  = f[int'(m_fid[id]) * THR_W +: THR_W];
            nx = (v <= m_thr[id]) ? int'(m_l[id]) : int'(m_r[id]);
            if (nx >= N_NODES || d + 1 >= MAX_STEPS) begin
                cls = 0; dep = d; err = 1;
                return;
            end
            id = nx;
            d++;
        end
    endfunction

    task automatic cfg_write(input logic [ID_W-1:0] a, input logic [FEAT_W-1:0] fid,
            input logic [THR_W-1:0] thr, input logic [ID_W-1:0] r, input logic [ID_W-1:0] l,
            input logic [7:0] ty);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = pack(a, fid, thr, r, l, ty);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        mset(a, fid, thr, r, l, ty);
    endtask

    task automatic accept(input logic [FV_W-1:0] f, input logic do_cfg,
            input logic [ID_W-1:0] ca, input logic [NODE_W-1:0] cd);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        in_features = f; in_valid = 1'b1;
        cfg_we = do_cfg; cfg_addr = ca; cfg_wdata = cd;
        @(posedge clk);
        #1 in_valid = 1'b0; cfg_we = 1'b0;
    endtask

    // Latency counts negedges after the accept edge up to the first one showing out_valid.
    task automatic collect(input string tag, input int lat0, input bit hold);
        int lat = lat0;
        bit seen = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_lat"}, lat, 2 * (e_dep + 1) + 1);
        chk({tag, "_cls"}, out_class, e_cls);
        chk({tag, "_dep"}, out_depth, e_dep);
        chk({tag, "_err"}, out_err, e_err);
        if (hold) begin
            in_valid = 1'b1;
            repeat (10) begin
                @(negedge clk);
                chk({tag, "_hold_vld"}, out_valid, 1);
                chk({tag, "_hold_cls"}, out_class, e_cls);
                chk({tag, "_hold_dep"}, out_depth, e_dep);
                chk({tag, "_hold_err"}, out_err, e_err);
                chk({tag, "_hold_rdy"}, in_ready, 0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [FV_W-1:0] f);
        model(f, e_cls, e_dep, e_err);
        accept(f, 1'b0, '0, '0);
        collect(tag, 0, 1'b0);
    endtask

    function automatic logic [FV_W-1:0] rand_feats(input int maxv);
        logic [FV_W-1:0] f = '0;
        for (int i = 0; i < N_FEAT; i++)
            f[i * THR_W +: THR_W] = THR_W'($urandom_range(0, maxv));
        return f;
    endfunction

    task automatic load_split_tree();
        cfg_write(8'd0, 3'd2, 27'd100, 8'd2, 8'd1, 8'd0);
        cfg_write(8'd1, 3'd0, 27'd1, 8'd0, 8'd0, 8'd1);
        cfg_write(8'd2, 3'd0, 27'd2, 8'd0, 8'd0, 8'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_depth", out_depth, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        for (int i = 0; i < 32; i++)
            cfg_write(ID_W'(i), 3'd0, THR_W'(i), 8'd0, 8'd0, 8'd1);

        // Root leaf, class 5.
        cfg_write(8'd0, 3'd0, 27'd5, 8'd0, 8'd0, 8'd1);
        @(negedge clk);
        chk("legal_wr_cfg_err", cfg_err, 0);
        run("leaf_root", rand_feats(1000));

        // One split on feature 2 at threshold 100.
        load_split_tree();
        fv = rand_feats(1000); fv[2 * THR_W +: THR_W] = 27'd100;
        run("split_eq", fv);
        fv[2 * THR_W +: THR_W] = 27'd101;
        run("split_gt", fv);
        fv[2 * THR_W +: THR_W] = 27'h7ffffff;
        run("split_max", fv);

        // Back-pressure: result held while out_ready is low.
        fv[2 * THR_W +: THR_W] = 27'd0;
        model(fv, e_cls, e_dep, e_err);
        accept(fv, 1'b0, '0, '0);
        collect("hold", 0, 1'b1);

        // Self-loop node with no children is a leaf.
        cfg_write(8'd0, 3'd4, 27'd42, 8'd0, 8'd0, 8'd0);
        run("self_loop", rand_feats(1000));

        // 0 -> 1 -> 0 cycle hits the step limit.
        cfg_write(8'd0, 3'd1, 27'd7, 8'd1, 8'd1, 8'd0);
        cfg_write(8'd1, 3'd0, 27'h7ffffff, 8'd1, 8'd0, 8'd0);
        run("cycle", rand_feats(1000));

        // Write while busy is dropped and flagged.
        load_split_tree();
        fv = rand_feats(1000); fv[2 * THR_W +: THR_W] = 27'd50;
        model(fv, e_cls, e_dep, e_err);
        accept(fv, 1'b0, '0, '0);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = pack(8'd0, 3'd0, 27'd99, 8'd0, 8'd0, 8'd1);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        @(negedge clk);
        chk("busy_cfg_err_hi", cfg_err, 1);
        @(negedge clk);
        chk("busy_cfg_err_lo", cfg_err, 0);
        collect("busy_wr", 3, 1'b0);
        run("busy_wr_kept", fv);

        // Write and accept on the same edge: new root is used.
        mset(8'd0, 3'd0, 27'd77, 8'd0, 8'd0, 8'd1);
        model(fv, e_cls, e_dep, e_err);
        accept(fv, 1'b1, 8'd0, pack(8'd0, 3'd0, 27'd77, 8'd0, 8'd0, 8'd1));
        collect("same_edge", 0, 1'b0);

        // Reset during EVAL aborts the walk and keeps RAM.
        load_split_tree();
        accept(fv, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy0", in_ready, 0);
        chk("mid_rst_vld0", out_valid, 0);
        @(negedge clk);
        chk("mid_rst_rdy1", in_ready, 1);
        repeat (6) begin
            @(negedge clk);
            chk("mid_rst_no_vld", out_valid, 0);
        end
        run("after_rst", fv);

        // Random trees over nodes 0..31, loops allowed.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++)
                cfg_write(ID_W'(i), FEAT_W'($urandom_range(0, 7)), THR_W'($urandom_range(0, 255)),
                          ID_W'($urandom_range(0, 31)), ID_W'($urandom_range(0, 31)),
                          8'($urandom_range(0, 3)));
            for (int q = 0; q < 25; q++)
                run("rand", rand_feats(255));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
